ntt_sequencer: RTL and testbench

//  Control stage around the butterfly pipeline: walks one 256-coefficient polynomial through all 8 NTT layers (forward or inverse).

---
 rtl/ntt_sequencer_if.sv | 17 +
 rtl/ntt_sequencer.sv | 101 ++++++++++
 tb/tb_ntt_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_sequencer_if.sv
// ntt_sequencer_if: control, read-issue and write-back signals between the NTT sequencer and its datapath.
interface ntt_sequencer_if #(parameter int AW = 8);
  logic start, inverse, busy, done;
  logic rd_en, bf_validi, bf_valido, wr_en, err_underflow;
  logic [AW-1:0] rd_addr_a, rd_addr_b, zeta_addr, wr_addr_a, wr_addr_b;
  logic [2:0] bf_mode;
  modport master (
    input start, inverse, bf_valido,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, zeta_addr, bf_mode, bf_validi,
    wr_en, wr_addr_a, wr_addr_b, err_underflow
  );
  modport slave (
    output start, inverse, bf_valido,
    input busy, done, rd_en, rd_addr_a, rd_addr_b, zeta_addr, bf_mode, bf_validi,
    wr_en, wr_addr_a, wr_addr_b, err_underflow
  );
endinterface

// File: rtl/ntt_sequencer.sv
// ntt_sequencer: walks one polynomial through all NTT layers, issuing butterfly reads and retiring write-backs.
module ntt_sequencer #(
  parameter int LOGN = 8,
  parameter int RD_LAT = 1,
  parameter int FIFO_DEPTH = 16
) (
  input logic clk,
  input logic rst,
  ntt_sequencer_if.master bus
);
  localparam int AW = LOGN;
  localparam int LW = $clog2(LOGN);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [LW-1:0] LAST = LW'(LOGN - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
  state_t state;
  logic inv, busy, done, err, rd_en, pop;
  logic [2:0] mode;
  logic [LW-1:0] layer;
  logic [LOGN-2:0] b;
  logic [RD_LAT-1:0] vld_d;
  logic [2*AW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [AW-1:0] s, len, g, j, zeta;
  // Entries are queued at issue time, so cnt already covers reads still in flight.
  always_comb begin
    s = inv ? AW'(layer) : AW'(LAST - layer);
    len = AW'(1) << s;
    g = AW'(b) >> s;
    j = (g << (s + 1'b1)) + (AW'(b) & (len - 1'b1));
    zeta = inv ? ({AW{1'b1}} >> layer) - g : (AW'(1) << layer) + g;
    rd_en = state == ISSUE && cnt < CW'(FIFO_DEPTH);
    pop = bus.bf_valido && cnt != '0;
  end
  assign bus.rd_en = rd_en;
  assign bus.rd_addr_a = rd_en ? j : '0;
  assign bus.rd_addr_b = rd_en ? j + len : '0;
  assign bus.zeta_addr = rd_en ? zeta : '0;
  assign bus.bf_validi = vld_d[RD_LAT-1];
  assign bus.wr_en = pop;
  assign {bus.wr_addr_a, bus.wr_addr_b} = cnt != '0 ? mem[rp] : '0;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.bf_mode = mode;
  assign bus.err_underflow = err;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      inv <= 1'b0;
      mode <= '0;
      layer <= '0;
      b <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      vld_d <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      vld_d <= RD_LAT'({vld_d, rd_en});
      err <= err | (bus.bf_valido && cnt == '0);
      cnt <= cnt + CW'(rd_en) - CW'(pop);
      done <= 1'b0;
      if (rd_en) begin
        mem[wp] <= {j, j + len};
        wp <= wp == PW'(FIFO_DEPTH - 1) ? '0 : wp + 1'b1;
      end
      if (pop) rp <= rp == PW'(FIFO_DEPTH - 1) ? '0 : rp + 1'b1;
      case (state)
        IDLE: if (bus.start) begin
          inv <= bus.inverse;
          mode <= {2'b0, bus.inverse};
          layer <= '0;
          b <= '0;
          busy <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: if (rd_en) begin
          b <= b + 1'b1;
          if (b == '1) state <= DRAIN;
        end
        // A layer may only start once every write of the previous one has retired.
        DRAIN: if (cnt == '0 && vld_d == '0) begin
          if (layer == LAST) begin
            state <= FIN;
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            layer <= layer + 1'b1;
            b <= '0;
            state <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ntt_sequencer.sv
// tb_ntt_sequencer: drives the sequencer with a RAM, zeta ROM and modular butterfly model; scoreboards every read and write.
module tb_ntt_sequencer;
  localparam int BF_LAT = 3;
  localparam int EXP_LAT = 8 * (128 + 1 + BF_LAT + 1) + 1;
  localparam longint Q = 8380417;
  localparam longint NINV = Q - (Q - 1) / 256;
  typedef struct packed {
    logic [2:0] layer;
    logic first;
    logic [7:0] a, b, z;
    logic [2:0] mode;
  } rd_t;
  typedef struct packed {
    logic [2:0] layer;
    logic [7:0] a, b;
  } wr_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_vo = 1'b0;
  logic init_req = 1'b0;
  logic v1, v2, v3;
  longint ram [256];
  longint zrom [256];
  longint ra, rb, zz, x1, y1, x2, y2, x3, y3;
  rd_t exp_rd [$];
  wr_t exp_wr [$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_wr = -100;
  ntt_sequencer_if sif ();
  ntt_sequencer dut (.clk(clk), .rst(rst), .bus(sif));
  always #5 clk = ~clk;
  assign sif.bf_valido = v3 | force_vo;
  always @(posedge clk) begin
    if (init_req) for (int i = 0; i < 256; i++) ram[i] <= (i == 0) ? 64'd1 : 64'd0;
    else if (sif.wr_en) begin
      ram[sif.wr_addr_a] <= x3;
      ram[sif.wr_addr_b] <= y3;
    end
    if (sif.rd_en) begin
      ra <= ram[sif.rd_addr_a];
      rb <= ram[sif.rd_addr_b];
      zz <= zrom[sif.zeta_addr];
    end
  end
  always @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v1 <= sif.bf_validi;
      v2 <= v1;
      v3 <= v2;
      x1 <= sif.bf_mode[0] ? (ra + rb) % Q : (ra + zz * rb % Q) % Q;
      y1 <= sif.bf_mode[0] ? zz * ((rb - ra + Q) % Q) % Q : (ra - zz * rb % Q + Q) % Q;
      x2 <= x1;
      y2 <= y1;
      x3 <= x2;
      y3 <= y2;
    end
  end
  function automatic longint powmod(longint base, int e);
    longint r = 1;
    for (int i = 0; i < e; i++) r = r * base % Q;
    return r;
  endfunction
  function automatic int brv8(int k);
    int r = 0;
    for (int i = 0; i < 8; i++) if (k[i]) r |= 1 << (7 - i);
    return r;
  endfunction
  // Reference loop nest: group-major, k counting up (forward) or down (inverse).
  task automatic push_expect(input bit inv);
    int k, l;
    k = inv ? 256 : 0;
    l = 0;
    for (int len = inv ? 1 : 128; len >= 1 && len <= 128; len = inv ? len * 2 : len / 2) begin
      for (int st = 0; st < 256; st += 2 * len) begin
        k = inv ? k - 1 : k + 1;
        for (int j = st; j < st + len; j++) begin
          exp_rd.push_back(rd_t'{3'(l), j == 0, 8'(j), 8'(j + len), 8'(k), 3'(inv)});
          exp_wr.push_back(wr_t'{3'(l), 8'(j), 8'(j + len)});
        end
      end
      l++;
    end
  endtask
  task automatic step();
    rd_t e;
    wr_t w;
    @(negedge clk);
    cyc++;
    if (sif.rd_en) begin
      n_chk++;
      if (exp_rd.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got a=%0d b=%0d z=%0d, expected no read", sif.rd_addr_a, sif.rd_addr_b, sif.zeta_addr);
      end else begin
        e = exp_rd.pop_front();
        if ({sif.rd_addr_a, sif.rd_addr_b, sif.zeta_addr, sif.bf_mode} !== {e.a, e.b, e.z, e.mode}) begin
          n_fail++;
          $display("FAIL rd_addr layer %0d: got a=%0d b=%0d z=%0d m=%0d, expected a=%0d b=%0d z=%0d m=%0d",
                   e.layer, sif.rd_addr_a, sif.rd_addr_b, sif.zeta_addr, sif.bf_mode, e.a, e.b, e.z, e.mode);
        end
        n_chk++;
        if (exp_wr.size() != 0 && exp_wr[0].layer != e.layer) begin
          n_fail++;
          $display("FAIL rd_before_drain: read for layer %0d, got pending write of layer %0d", e.layer, exp_wr[0].layer);
        end
        if (e.first && e.layer != 0) begin
          n_chk++;
          if (cyc - last_wr != 2) begin
            n_fail++;
            $display("FAIL drain_gap layer %0d: got %0d cycles from last write, expected 2", e.layer, cyc - last_wr);
          end
        end
      end
    end
    if (sif.wr_en) begin
      n_chk++;
      if (exp_wr.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got a=%0d b=%0d, expected no write", sif.wr_addr_a, sif.wr_addr_b);
      end else begin
        w = exp_wr.pop_front();
        if ({sif.wr_addr_a, sif.wr_addr_b} !== {w.a, w.b}) begin
          n_fail++;
          $display("FAIL wr_addr layer %0d: got a=%0d b=%0d, expected a=%0d b=%0d", w.layer, sif.wr_addr_a, sif.wr_addr_b, w.a, w.b);
        end
      end
      last_wr = cyc;
    end
  endtask
  task automatic load_delta();
    init_req = 1'b1;
    step();
    init_req = 1'b0;
  endtask
  task automatic launch(input bit inv);
    push_expect(inv);
    sif.start = 1'b1;
    sif.inverse = inv;
    step();
    sif.start = 1'b0;
    sif.inverse = 1'b0;
  endtask
  task automatic run_to_done(output int n);
    n = 1;
    while (!sif.done && n < 3000) begin
      step();
      n++;
    end
  endtask
  task automatic test_reset();
    sif.start = 1'b0;
    sif.inverse = 1'b0;
    rst = 1'b1;
    step();
    step();
    n_chk++;
    if ({sif.busy, sif.done, sif.rd_en, sif.bf_validi, sif.wr_en, sif.err_underflow} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got busy/done/rd/bfv/wr/err=%b, expected 000000",
               {sif.busy, sif.done, sif.rd_en, sif.bf_validi, sif.wr_en, sif.err_underflow});
    end
    n_chk++;
    if ({sif.rd_addr_a, sif.rd_addr_b, sif.zeta_addr} !== 24'b0) begin
      n_fail++;
      $display("FAIL reset_rd_addr: got %0d %0d %0d, expected 0 0 0", sif.rd_addr_a, sif.rd_addr_b, sif.zeta_addr);
    end
    n_chk++;
    if ({sif.wr_addr_a, sif.wr_addr_b, sif.bf_mode} !== 19'b0) begin
      n_fail++;
      $display("FAIL reset_wr_mode: got %0d %0d mode %0d, expected 0 0 0", sif.wr_addr_a, sif.wr_addr_b, sif.bf_mode);
    end
    rst = 1'b0;
    step();
  endtask
  task automatic test_forward();
    int n;
    load_delta();
    launch(1'b0);
    n_chk++;
    if (sif.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL fwd_busy: got %b, expected 1", sif.busy);
    end
    run_to_done(n);
    n_chk++;
    if (n != EXP_LAT) begin
      n_fail++;
      $display("FAIL fwd_latency: got %0d, expected %0d", n, EXP_LAT);
    end
    n_chk++;
    if ({sif.busy, exp_rd.size() == 0, exp_wr.size() == 0} !== 3'b011) begin
      n_fail++;
      $display("FAIL fwd_end: got busy=%b rd_left=%0d wr_left=%0d, expected 0 0 0", sif.busy, exp_rd.size(), exp_wr.size());
    end
    step();
    n_chk++;
    if ({sif.done, sif.bf_mode, sif.err_underflow} !== 5'b0) begin
      n_fail++;
      $display("FAIL fwd_after_done: got done=%b mode=%0d err=%b, expected 0 0 0", sif.done, sif.bf_mode, sif.err_underflow);
    end
    for (int i = 0; i < 256; i++) begin
      n_chk++;
      if (ram[i] != 1) begin
        n_fail++;
        $display("FAIL fwd_coef[%0d]: got %0d, expected 1", i, ram[i]);
      end
    end
  endtask
  task automatic test_inverse();
    int n;
    launch(1'b1);
    run_to_done(n);
    n_chk++;
    if (n != EXP_LAT) begin
      n_fail++;
      $display("FAIL inv_latency: got %0d, expected %0d", n, EXP_LAT);
    end
    n_chk++;
    if ({exp_rd.size() == 0, exp_wr.size() == 0} !== 2'b11) begin
      n_fail++;
      $display("FAIL inv_end: got rd_left=%0d wr_left=%0d, expected 0 0", exp_rd.size(), exp_wr.size());
    end
    repeat (3) step();
    n_chk++;
    if (sif.bf_mode !== 3'd1) begin
      n_fail++;
      $display("FAIL inv_mode_hold: got %0d, expected 1", sif.bf_mode);
    end
    for (int i = 0; i < 256; i++) begin
      n_chk++;
      if (ram[i] * NINV % Q != ((i == 0) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL inv_coef[%0d]: got %0d (scaled %0d), expected %0d", i, ram[i], ram[i] * NINV % Q, (i == 0) ? 1 : 0);
      end
    end
  endtask
  task automatic test_busy_and_reset();
    int n;
    load_delta();
    launch(1'b0);
    repeat (300) step();
    sif.start = 1'b1;
    sif.inverse = 1'b1;
    step();
    sif.start = 1'b0;
    sif.inverse = 1'b0;
    n_chk++;
    if ({sif.busy, sif.bf_mode} !== 4'b1000) begin
      n_fail++;
      $display("FAIL start_while_busy: got busy=%b mode=%0d, expected 1 0", sif.busy, sif.bf_mode);
    end
    n = 0;
    while (exp_rd.size() != 0 && exp_rd[0].layer != 3'd3 && n < 2000) begin
      step();
      n++;
    end
    n_chk++;
    if (exp_rd.size() == 0 || exp_rd[0].layer != 3'd3) begin
      n_fail++;
      $display("FAIL reach_layer3: got %0d reads left after %0d cycles, expected layer 3 pending", exp_rd.size(), n);
    end
    repeat (40) step();
    rst = 1'b1;
    exp_rd.delete();
    exp_wr.delete();
    step();
    rst = 1'b0;
    n_chk++;
    if ({sif.busy, sif.wr_en, sif.rd_en, sif.done, sif.wr_addr_a, sif.wr_addr_b} !== 20'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got busy=%b wr=%b rd=%b done=%b head=%0d/%0d, expected all 0",
               sif.busy, sif.wr_en, sif.rd_en, sif.done, sif.wr_addr_a, sif.wr_addr_b);
    end
    load_delta();
    launch(1'b0);
    run_to_done(n);
    n_chk++;
    if (n != EXP_LAT || exp_rd.size() != 0 || exp_wr.size() != 0) begin
      n_fail++;
      $display("FAIL rerun: got latency=%0d rd_left=%0d wr_left=%0d, expected %0d 0 0", n, exp_rd.size(), exp_wr.size(), EXP_LAT);
    end
    step();
    for (int i = 0; i < 256; i += 37) begin
      n_chk++;
      if (ram[i] != 1) begin
        n_fail++;
        $display("FAIL rerun_coef[%0d]: got %0d, expected 1", i, ram[i]);
      end
    end
  endtask
  task automatic test_underflow();
    step();
    force_vo = 1'b1;
    #1;
    n_chk++;
    if (sif.wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_wr: got %b, expected 0", sif.wr_en);
    end
    step();
    force_vo = 1'b0;
    n_chk++;
    if (sif.err_underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow_set: got %b, expected 1", sif.err_underflow);
    end
    repeat (5) step();
    n_chk++;
    if (sif.err_underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow_sticky: got %b, expected 1", sif.err_underflow);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++;
    if (sif.err_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_clear: got %b, expected 0", sif.err_underflow);
    end
  endtask
  initial begin
    for (int k = 0; k < 256; k++) zrom[k] = powmod(64'd1753, brv8(k));
    test_reset();
    test_forward();
    test_inverse();
    test_busy_and_reset();
    test_underflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
